// File: rtl/mem_channel_mux_if.sv
// Bus bundle between the cache-side memory channels, the channel mux and the
// single external global-memory port.
interface mem_channel_mux_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8
);
  logic [NUM_CHANNELS-1:0]           ch_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address;
  logic [NUM_CHANNELS-1:0]           ch_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data;
  logic [NUM_CHANNELS-1:0]           ch_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data;
  logic [NUM_CHANNELS-1:0]           ch_write_ready;
  logic                              ext_read_valid;
  logic [ADDR_BITS-1:0]              ext_read_address;
  logic                              ext_read_ready;
  logic [DATA_BITS-1:0]              ext_read_data;
  logic                              ext_write_valid;
  logic [ADDR_BITS-1:0]              ext_write_address;
  logic [DATA_BITS-1:0]              ext_write_data;
  logic                              ext_write_ready;

  // The mux: serves the channels, drives the external memory port.
  modport master (
    input  ch_read_valid, ch_read_address, ch_write_valid, ch_write_address, ch_write_data,
    input  ext_read_ready, ext_read_data, ext_write_ready,
    output ch_read_ready, ch_read_data, ch_write_ready,
    output ext_read_valid, ext_read_address, ext_write_valid, ext_write_address, ext_write_data
  );

  // The environment: channel requesters plus the external memory.
  modport slave (
    output ch_read_valid, ch_read_address, ch_write_valid, ch_write_address, ch_write_data,
    output ext_read_ready, ext_read_data, ext_write_ready,
    input  ch_read_ready, ch_read_data, ch_write_ready,
    input  ext_read_valid, ext_read_address, ext_write_valid, ext_write_address, ext_write_data
  );
endinterface

// File: rtl/mem_channel_mux.sv
// Round-robin merge of NUM_CHANNELS read/write memory channels onto one external
// memory port, one external transaction in flight, with an optional watchdog.
module mem_channel_mux #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_channel_mux_if.master bus,
  output logic              timeout_err
);
  localparam int PTR_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SUM_BITS = PTR_BITS + 1;
  localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PTR_BITS-1:0] LAST_CH  = PTR_BITS'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EXT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                            state_r, state_s;
  logic [PTR_BITS-1:0]               rr_ptr_r, rr_ptr_s;
  logic [PTR_BITS-1:0]               ch_r, ch_s;
  logic [PTR_BITS-1:0]               pick_s;
  logic                              is_read_r, is_read_s;
  logic [NUM_CHANNELS-1:0]           blocked_r, blocked_s;
  logic [NUM_CHANNELS-1:0]           elig_s;
  logic [CNT_BITS-1:0]               wait_cnt_r, wait_cnt_s;
  logic                              ext_read_valid_r, ext_read_valid_s;
  logic                              ext_write_valid_r, ext_write_valid_s;
  logic [ADDR_BITS-1:0]              ext_read_address_r, ext_read_address_s;
  logic [ADDR_BITS-1:0]              ext_write_address_r, ext_write_address_s;
  logic [DATA_BITS-1:0]              ext_write_data_r, ext_write_data_s;
  logic [NUM_CHANNELS-1:0]           ch_read_ready_r, ch_read_ready_s;
  logic [NUM_CHANNELS-1:0]           ch_write_ready_r, ch_write_ready_s;
  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data_r, ch_read_data_s;
  logic                              timeout_err_r, timeout_err_s;
  logic                              ext_done_s;
  logic                              expired_s;

  // First set bit of elig scanning upward from ptr with wrap-around.
  function automatic logic [PTR_BITS-1:0] rr_pick(input logic [NUM_CHANNELS-1:0] elig,
                                                 input logic [PTR_BITS-1:0]     ptr);
    logic [PTR_BITS-1:0] pick;
    logic [SUM_BITS-1:0] sum;
    logic [PTR_BITS-1:0] idx;
    logic                hit;
    pick = ptr;
    hit  = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum  = {1'b0, ptr} + SUM_BITS'(i);
      sum  = (sum >= SUM_BITS'(NUM_CHANNELS)) ? sum - SUM_BITS'(NUM_CHANNELS) : sum;
      idx  = sum[PTR_BITS-1:0];
      pick = (!hit && elig[idx]) ? idx : pick;
      hit  = hit | elig[idx];
    end
    return pick;
  endfunction

  assign elig_s     = (bus.ch_read_valid | bus.ch_write_valid) & ~blocked_r;
  assign pick_s     = rr_pick(elig_s, rr_ptr_r);
  assign ext_done_s = is_read_r ? bus.ext_read_ready : bus.ext_write_ready;
  assign expired_s  = WDOG_EN && (wait_cnt_r == CNT_LAST);

  // Next-state and next-output computation for the grant/wait/done sequence.
  always_comb begin
    state_s             = state_r;
    rr_ptr_s            = rr_ptr_r;
    ch_s                = ch_r;
    is_read_s           = is_read_r;
    wait_cnt_s          = wait_cnt_r;
    ext_read_valid_s    = ext_read_valid_r;
    ext_write_valid_s   = ext_write_valid_r;
    ext_read_address_s  = ext_read_address_r;
    ext_write_address_s = ext_write_address_r;
    ext_write_data_s    = ext_write_data_r;
    ch_read_ready_s     = '0;
    ch_write_ready_s    = '0;
    ch_read_data_s      = ch_read_data_r;
    timeout_err_s       = timeout_err_r;
    // A channel stays blocked until its requester has visibly dropped both valids.
    blocked_s           = blocked_r & (bus.ch_read_valid | bus.ch_write_valid);

    case (state_r)
      IDLE: begin
        if ((|elig_s) && !bus.ext_read_ready && !bus.ext_write_ready) begin
          ch_s       = pick_s;
          is_read_s  = bus.ch_read_valid[pick_s];
          rr_ptr_s   = (pick_s == LAST_CH) ? PTR_BITS'(0) : pick_s + PTR_BITS'(1);
          wait_cnt_s = '0;
          if (bus.ch_read_valid[pick_s]) begin
            ext_read_valid_s   = 1'b1;
            ext_read_address_s = bus.ch_read_address[int'(pick_s)*ADDR_BITS +: ADDR_BITS];
          end else begin
            ext_write_valid_s   = 1'b1;
            ext_write_address_s = bus.ch_write_address[int'(pick_s)*ADDR_BITS +: ADDR_BITS];
            ext_write_data_s    = bus.ch_write_data[int'(pick_s)*DATA_BITS +: DATA_BITS];
          end
          state_s = WAIT_EXT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_EXT: begin
        if (ext_done_s || expired_s) begin
          ext_read_valid_s  = 1'b0;
          ext_write_valid_s = 1'b0;
          if (is_read_r) begin
            ch_read_data_s[int'(ch_r)*DATA_BITS +: DATA_BITS] =
                ext_done_s ? bus.ext_read_data : {DATA_BITS{1'b0}};
            ch_read_ready_s[ch_r] = 1'b1;
          end else begin
            ch_write_ready_s[ch_r] = 1'b1;
          end
          blocked_s[ch_r] = 1'b1;
          timeout_err_s   = timeout_err_r | ~ext_done_s;
          state_s         = DONE;
        end else begin
          wait_cnt_s = wait_cnt_r + CNT_BITS'(1);
          state_s    = WAIT_EXT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Register update; reset abandons any in-flight external transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      rr_ptr_r            <= '0;
      ch_r                <= '0;
      is_read_r           <= 1'b0;
      wait_cnt_r          <= '0;
      blocked_r           <= '0;
      ext_read_valid_r    <= 1'b0;
      ext_write_valid_r   <= 1'b0;
      ext_read_address_r  <= '0;
      ext_write_address_r <= '0;
      ext_write_data_r    <= '0;
      ch_read_ready_r     <= '0;
      ch_write_ready_r    <= '0;
      ch_read_data_r      <= '0;
      timeout_err_r       <= 1'b0;
    end else begin
      state_r             <= state_s;
      rr_ptr_r            <= rr_ptr_s;
      ch_r                <= ch_s;
      is_read_r           <= is_read_s;
      wait_cnt_r          <= wait_cnt_s;
      blocked_r           <= blocked_s;
      ext_read_valid_r    <= ext_read_valid_s;
      ext_write_valid_r   <= ext_write_valid_s;
      ext_read_address_r  <= ext_read_address_s;
      ext_write_address_r <= ext_write_address_s;
      ext_write_data_r    <= ext_write_data_s;
      ch_read_ready_r     <= ch_read_ready_s;
      ch_write_ready_r    <= ch_write_ready_s;
      ch_read_data_r      <= ch_read_data_s;
      timeout_err_r       <= timeout_err_s;
    end
  end

  assign bus.ext_read_valid    = ext_read_valid_r;
  assign bus.ext_read_address  = ext_read_address_r;
  assign bus.ext_write_valid   = ext_write_valid_r;
  assign bus.ext_write_address = ext_write_address_r;
  assign bus.ext_write_data    = ext_write_data_r;
  assign bus.ch_read_ready     = ch_read_ready_r;
  assign bus.ch_write_ready    = ch_write_ready_r;
  assign bus.ch_read_data      = ch_read_data_r;
  assign timeout_err           = timeout_err_r;
endmodule

// File: tb/tb_mem_channel_mux.sv
// Scoreboard bench for mem_channel_mux: expected ext requests and channel
// responses are queued at stimulus time and checked by independent monitors.
module tb_mem_channel_mux;
  localparam int NCH = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic timeout_err;

  mem_channel_mux_if #(.NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_channel_mux #(
    .NUM_CHANNELS(NCH), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit rd; logic [7:0] addr; logic [7:0] wdata; } ext_t;
  typedef struct { bit rd; int ch; logic [7:0] data; } rsp_t;

  ext_t       ext_q[$];
  rsp_t       rsp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [256];
  int         ext_delay = 1;
  bit         hang = 1'b0;
  int         mem_cnt = 0;
  int         last_wait = 0;
  logic [3:0] rd_pend = 4'd0;
  logic [3:0] wr_pend = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External memory model: answers after ext_delay sampled cycles unless hung.
  initial begin
    bus.ext_read_ready  = 1'b0;
    bus.ext_write_ready = 1'b0;
    bus.ext_read_data   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h92;
    forever begin
      @(negedge clk);
      if (reset || !(bus.ext_read_valid || bus.ext_write_valid)) begin
        bus.ext_read_ready  = 1'b0;
        bus.ext_write_ready = 1'b0;
        mem_cnt = 0;
      end else if (!(bus.ext_read_ready || bus.ext_write_ready)) begin
        mem_cnt++;
        if (!hang && mem_cnt >= ext_delay) begin
          if (bus.ext_read_valid) begin
            bus.ext_read_data  = mem[bus.ext_read_address];
            bus.ext_read_ready = 1'b1;
          end else begin
            mem[bus.ext_write_address] = bus.ext_write_data;
            bus.ext_write_ready = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: ext request order/stability and channel response pulses.
  initial begin
    ext_t       cur;
    rsp_t       e;
    bit         active;
    int         wcnt;
    logic       rdy_prev;
    logic [3:0] rr, wr, rr_prev, wr_prev;
    active = 1'b0; wcnt = 0; rdy_prev = 1'b0; rr_prev = 4'd0; wr_prev = 4'd0;
    cur = '{rd: 1'b0, addr: 8'h00, wdata: 8'h00};
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rdy_prev)
          check("ext_valid_drop", 32'({bus.ext_read_valid, bus.ext_write_valid}), 32'd0);
        if (bus.ext_read_valid || bus.ext_write_valid) begin
          if (!active) begin
            if (ext_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL ext_unexpected: got request rd=%0b addr 0x%0h, expected none",
                       bus.ext_read_valid, bus.ext_read_valid ? bus.ext_read_address : bus.ext_write_address);
              cur = '{rd: bus.ext_read_valid, addr: 8'h00, wdata: 8'h00};
            end else begin
              cur = ext_q.pop_front();
            end
            active = 1'b1;
            wcnt   = 0;
          end
          wcnt++;
          check("ext_op", 32'({bus.ext_read_valid, bus.ext_write_valid}), cur.rd ? 32'd2 : 32'd1);
          if (cur.rd) begin
            check("ext_raddr", 32'(bus.ext_read_address), 32'(cur.addr));
          end else begin
            check("ext_waddr", 32'(bus.ext_write_address), 32'(cur.addr));
            check("ext_wdata", 32'(bus.ext_write_data), 32'(cur.wdata));
          end
        end else begin
          if (active) last_wait = wcnt;
          active = 1'b0;
        end
        rdy_prev = (bus.ext_read_valid & bus.ext_read_ready) | (bus.ext_write_valid & bus.ext_write_ready);
        rr = bus.ch_read_ready;
        wr = bus.ch_write_ready;
        if ((rr | wr) != 4'd0) begin
          check("ready_onehot", 32'($countones(rr | wr)), 32'd1);
          check("ready_pulse", 32'((rr & rr_prev) | (wr & wr_prev)), 32'd0);
        end
        for (int c = 0; c < NCH; c++) begin
          if (rr[c] || wr[c]) begin
            if (rsp_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL rsp_unexpected: got ready on ch%0d, expected none", c);
            end else begin
              e = rsp_q.pop_front();
              check("rsp_ch", 32'(c), 32'(e.ch));
              check("rsp_op", 32'(rr[c]), 32'(e.rd));
              if (rr[c]) check("rsp_rdata", 32'(bus.ch_read_data[c*8 +: 8]), 32'(e.data));
            end
          end
        end
        rr_prev = rr;
        wr_prev = wr;
      end else begin
        active = 1'b0; rdy_prev = 1'b0; rr_prev = 4'd0; wr_prev = 4'd0;
      end
    end
  end

  task automatic req_read(input int c, input logic [7:0] addr, input logic [7:0] data);
    bus.ch_read_address[c*8 +: 8] = addr;
    ext_q.push_back('{rd: 1'b1, addr: addr, wdata: 8'h00});
    rsp_q.push_back('{rd: 1'b1, ch: c, data: data});
    rd_pend[c] = 1'b1;
  endtask

  task automatic req_write(input int c, input logic [7:0] addr, input logic [7:0] wdata);
    bus.ch_write_address[c*8 +: 8] = addr;
    bus.ch_write_data[c*8 +: 8]    = wdata;
    ext_q.push_back('{rd: 1'b0, addr: addr, wdata: wdata});
    rsp_q.push_back('{rd: 1'b0, ch: c, data: 8'h00});
    wr_pend[c] = 1'b1;
  endtask

  // Requesters hold valid until ready, then drop both valids of that channel two
  // cycles late for one cycle; anything still pending is raised again afterwards.
  task automatic serve(input int max_cycles);
    logic [3:0] rr_d1, wr_d1, rr_d2, wr_d2, hold;
    int n;
    rr_d1 = 4'd0; wr_d1 = 4'd0; rr_d2 = 4'd0; wr_d2 = 4'd0; n = 0;
    bus.ch_read_valid  = rd_pend;
    bus.ch_write_valid = wr_pend;
    while (((rd_pend | wr_pend) != 4'd0) && (n < max_cycles)) begin
      @(negedge clk);
      n++;
      rd_pend = rd_pend & ~rr_d2;
      wr_pend = wr_pend & ~wr_d2;
      hold    = rr_d2 | wr_d2;
      bus.ch_read_valid  = rd_pend & ~hold;
      bus.ch_write_valid = wr_pend & ~hold;
      rr_d2 = rr_d1; wr_d2 = wr_d1;
      rr_d1 = bus.ch_read_ready; wr_d1 = bus.ch_write_ready;
    end
    check("serve_done", 32'(rd_pend | wr_pend), 32'd0);
    rd_pend = 4'd0; wr_pend = 4'd0;
    bus.ch_read_valid = 4'd0; bus.ch_write_valid = 4'd0;
    repeat (4) @(negedge clk);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("ext_q_drained", 32'(ext_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ext_rv"},  32'(bus.ext_read_valid), 32'd0);
    check({tag, "_ext_wv"},  32'(bus.ext_write_valid), 32'd0);
    check({tag, "_ext_ra"},  32'(bus.ext_read_address), 32'd0);
    check({tag, "_ext_wa"},  32'(bus.ext_write_address), 32'd0);
    check({tag, "_ext_wd"},  32'(bus.ext_write_data), 32'd0);
    check({tag, "_ch_rrdy"}, 32'(bus.ch_read_ready), 32'd0);
    check({tag, "_ch_wrdy"}, 32'(bus.ch_write_ready), 32'd0);
    check({tag, "_ch_rdat"}, 32'(bus.ch_read_data), 32'd0);
    check({tag, "_tmo_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n;
    bus.ch_read_valid = 4'd0; bus.ch_read_address = 32'd0;
    bus.ch_write_valid = 4'd0; bus.ch_write_address = 32'd0; bus.ch_write_data = 32'd0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // All four read at once; grants rotate 0..3, none served twice.
    ext_delay = 1;
    req_read(0, 8'h40, 8'hD2);
    req_read(1, 8'h41, 8'hD3);
    req_read(2, 8'h42, 8'hD0);
    req_read(3, 8'h43, 8'hD1);
    serve(200);

    // ch1 read and write together: read first, write after.
    req_read(1, 8'h21, 8'hB3);
    req_write(1, 8'h22, 8'h77);
    serve(200);

    // Single read on ch2, memory answers after 3 cycles.
    ext_delay = 3;
    req_read(2, 8'h35, 8'hA7);
    serve(200);
    check("rd_wait_cycles", 32'(last_wait), 32'd3);
    check("rd_data_ch2", 32'(bus.ch_read_data[23:16]), 32'h0000_00A7);

    // Write on ch3, then read it back through ch0.
    req_write(3, 8'h10, 8'h5C);
    serve(200);
    check("rd_data_ch2_held", 32'(bus.ch_read_data[23:16]), 32'h0000_00A7);
    req_read(0, 8'h10, 8'h5C);
    serve(200);

    // Watchdog: memory never answers.
    hang = 1'b1;
    req_read(2, 8'h50, 8'h00);
    serve(60);
    check("tmo_wait_cycles", 32'(last_wait), 32'd8);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    hang = 1'b0;
    ext_delay = 2;
    req_write(3, 8'h60, 8'h11);
    serve(200);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_EXT.
    hang = 1'b1;
    req_read(0, 8'h70, 8'h00);
    bus.ch_read_valid = rd_pend;
    n = 0;
    while (!bus.ext_read_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_grant_seen", 32'(bus.ext_read_valid), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_pend = 4'd0;
    bus.ch_read_valid = 4'd0;
    @(negedge clk);
    check_idle("rst_mid");
    reset = 1'b0;
    hang = 1'b0;
    rsp_q.delete();
    ext_delay = 1;
    @(negedge clk);

    // Pointer back at 0: ch0 before ch3.
    req_read(0, 8'h08, 8'h9A);
    req_read(3, 8'h0C, 8'h9E);
    serve(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no end of test, expected finish before 200000");
    $fatal(1, "simulation time limit");
  end
endmodule
